// File: rtl/gcm_pkg.sv
// Shared GCM constants, GHASH sequencer state encoding and the GF(2^128) V-update step.
// Vectors are declared [0:127] so that index 0 is the x^0 coefficient (the block MSB).
package gcm_pkg;

    localparam int GCM_BLK_W  = 128;
    localparam int MUL_CYCLES = 128;

    localparam logic [0:GCM_BLK_W-1] GCM_R = {8'hE1, 120'd0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_LMUL,
        ST_DONE
    } ghash_state_e;

    // V <- V*x mod P: a right shift toward x^127, folding the overflow back in through R.
    function automatic logic [0:GCM_BLK_W-1] gf_shift(input logic [0:GCM_BLK_W-1] v);
        return v[GCM_BLK_W-1] ? ((v >> 1) ^ GCM_R) : (v >> 1);
    endfunction

endpackage

// File: rtl/ghash_gfmul_core.sv
// Bit-serial GF(2^128) multiplier that computes Z = X*H, one bit of X per cycle.
// The first iteration runs on the start edge, so Z is final CYCLES-1 edges later and oDone pulses.
module ghash_gfmul_core
    import gcm_pkg::*;
#(
    parameter int CYCLES = MUL_CYCLES
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iStart,
    input  logic [0:GCM_BLK_W-1]   iX,
    input  logic [0:GCM_BLK_W-1]   iH,
    output logic [0:GCM_BLK_W-1]   oZ,
    output logic                   oDone
);

    localparam int CNT_W = $clog2(CYCLES);

    logic [0:GCM_BLK_W-1] z;
    logic [0:GCM_BLK_W-1] v;
    logic [CNT_W-1:0]     cnt;
    logic                 run;
    logic                 done;
    logic                 last;

    assign last = (cnt == CNT_W'(CYCLES - 1));

    // iX must stay valid for the whole run: the controller presents its X register after the start edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            z    <= '0;
            v    <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else if (iStart) begin
            z    <= iX[0] ? iH : '0;
            v    <= gf_shift(iH);
            cnt  <= CNT_W'(1);
            run  <= 1'b1;
            done <= 1'b0;
        end else if (run) begin
            if (iX[cnt])
                z <= z ^ v;
            v    <= gf_shift(v);
            cnt  <= cnt + CNT_W'(1);
            run  <= !last;
            done <= last;
        end else begin
            done <= 1'b0;
        end
    end

    assign oZ    = z;
    assign oDone = done;

endmodule

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: folds each accepted block into Y via the serial multiplier, then the
// {len(A), len(C)} block, and presents the final S until the next start or reset.
module ghash_ctrl
    import gcm_pkg::GCM_BLK_W, gcm_pkg::ghash_state_e,
           gcm_pkg::ST_IDLE, gcm_pkg::ST_LOAD, gcm_pkg::ST_MUL,
           gcm_pkg::ST_LMUL, gcm_pkg::ST_DONE;
#(
    parameter int LEN_W      = 64,
    parameter int MUL_CYCLES = gcm_pkg::MUL_CYCLES
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iStart,
    input  logic [GCM_BLK_W-1:0]   iHashkey,
    input  logic [GCM_BLK_W-1:0]   iBlock,
    input  logic                   iBlock_valid,
    output logic                   oBlock_ready,
    input  logic                   iFinal,
    input  logic [LEN_W-1:0]       iLen_aad,
    input  logic [LEN_W-1:0]       iLen_ct,
    output logic [GCM_BLK_W-1:0]   oGhash,
    output logic                   oGhash_valid,
    output logic                   oBusy
);

    ghash_state_e         state;
    logic [0:GCM_BLK_W-1] h;
    logic [0:GCM_BLK_W-1] y;
    logic [0:GCM_BLK_W-1] x;
    logic [0:GCM_BLK_W-1] ghash;
    logic                 ghash_valid;
    logic                 ready;
    logic                 busy;

    logic                 mul_start;
    logic [0:GCM_BLK_W-1] x_next;
    logic [0:GCM_BLK_W-1] core_x;
    logic [0:GCM_BLK_W-1] core_z;
    logic                 core_done;

    // A block beats iFinal in the same cycle; iStart beats both.
    assign mul_start = (state == ST_LOAD) && !iStart && (iBlock_valid || iFinal);
    assign x_next    = iBlock_valid ? (y ^ iBlock) : (y ^ {iLen_aad, iLen_ct});
    // The core consumes bit 0 on the start edge, before X has been registered.
    assign core_x    = mul_start ? x_next : x;

    ghash_gfmul_core #(
        .CYCLES (MUL_CYCLES)
    ) u_core (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (mul_start),
        .iX     (core_x),
        .iH     (h),
        .oZ     (core_z),
        .oDone  (core_done)
    );

    // An aborted multiplication keeps running in the core; its done is ignored outside MUL/LMUL
    // and a new start reloads it.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state       <= ST_IDLE;
            h           <= '0;
            y           <= '0;
            x           <= '0;
            ghash       <= '0;
            ghash_valid <= 1'b0;
            ready       <= 1'b0;
            busy        <= 1'b0;
        end else if (iStart) begin
            h           <= iHashkey;
            y           <= '0;
            ghash_valid <= 1'b0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_LOAD;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_LOAD: begin
                    if (mul_start) begin
                        x     <= x_next;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= iBlock_valid ? ST_MUL : ST_LMUL;
                    end
                end
                ST_MUL: begin
                    if (core_done) begin
                        y     <= core_z;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_LOAD;
                    end
                end
                ST_LMUL: begin
                    if (core_done) begin
                        y           <= core_z;
                        ghash       <= core_z;
                        ghash_valid <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign oGhash       = ghash;
    assign oGhash_valid = ghash_valid;
    assign oBlock_ready = ready;
    assign oBusy        = busy;

endmodule

// File: tb/tb_ghash_ctrl.sv
// Directed bench for ghash_ctrl: message table against hand values / reference GHASH,
// plus collision, abort and reset sequences.
module tb_ghash_ctrl;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic         iStart = 1'b0;
    logic [127:0] iHashkey = '0;
    logic [127:0] iBlock = '0;
    logic         iBlock_valid = 1'b0;
    logic         oBlock_ready;
    logic         iFinal = 1'b0;
    logic [63:0]  iLen_aad = '0;
    logic [63:0]  iLen_ct = '0;
    logic [127:0] oGhash;
    logic         oGhash_valid;
    logic         oBusy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ghash_ctrl dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iStart       (iStart),
        .iHashkey     (iHashkey),
        .iBlock       (iBlock),
        .iBlock_valid (iBlock_valid),
        .oBlock_ready (oBlock_ready),
        .iFinal       (iFinal),
        .iLen_aad     (iLen_aad),
        .iLen_ct      (iLen_ct),
        .oGhash       (oGhash),
        .oGhash_valid (oGhash_valid),
        .oBusy        (oBusy)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0]       h;
        logic [2:0][127:0]  blk;
        int                 nblk;
        logic [63:0]        la;
        logic [63:0]        lc;
        logic [127:0]       exp;
    } vec_t;

    vec_t tbl[6];

    // Reference multiply in plain MSB-first value order (NIST right-shift algorithm).
    function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] z = '0;
        logic [127:0] v = b;
        for (int i = 0; i < 128; i++) begin
            if (a[127-i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ {8'hE1, 120'd0}) : (v >> 1);
        end
        return z;
    endfunction

    function automatic logic [127:0] ghash_ref(input vec_t v);
        logic [127:0] y = '0;
        for (int b = 0; b < v.nblk; b++) y = gf_mul(y ^ v.blk[b], v.h);
        return gf_mul(y ^ {v.la, v.lc}, v.h);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!oBlock_ready && n < 300) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_ghash(output int n);
        n = 0;
        while (!oGhash_valid && n < 300) begin
            n++;
            tick();
        end
    endtask

    // Block and length phase of a message, starting in LOAD.
    task automatic send_body(input vec_t v, input string tag);
        int n;
        int prev;
        int acc;
        prev = 0;
        for (int b = 0; b < v.nblk; b++) begin
            wait_ready(n);
            if (n >= 300) check({tag, "_rdy_timeout"}, 128'(n), 128'd0);
            iBlock = v.blk[b];
            iBlock_valid = 1'b1;
            tick();
            iBlock_valid = 1'b0;
            acc = cyc;
            check({tag, "_busy"}, 128'(oBusy), 128'd1);
            if (b > 0) check({tag, "_spacing"}, 128'(acc - prev), 128'd129);
            prev = acc;
            wait_ready(n);
            check({tag, "_rdy_low"}, 128'(n), 128'd128);
        end
        iLen_aad = v.la;
        iLen_ct = v.lc;
        iFinal = 1'b1;
        tick();
        iFinal = 1'b0;
        wait_ghash(n);
        check({tag, "_final_lat"}, 128'(n), 128'd128);
        check({tag, "_ghash"}, oGhash, v.exp);
        check({tag, "_done_flags"}, {126'd0, oBlock_ready, oBusy}, 128'd0);
        // DONE must ignore further blocks and finals
        iBlock_valid = 1'b1;
        iFinal = 1'b1;
        iBlock = ~v.exp;
        repeat (3) tick();
        iBlock_valid = 1'b0;
        iFinal = 1'b0;
        check({tag, "_done_hold"}, {oGhash_valid, oGhash[126:0]}, {1'b1, v.exp[126:0]});
    endtask

    task automatic run_msg(input vec_t v, input string tag);
        iHashkey = v.h;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        check({tag, "_start"}, {125'd0, oBlock_ready, oBusy, oGhash_valid}, 128'b100);
        send_body(v, tag);
    endtask

    initial begin
        vec_t va;
        int n;
        logic [127:0] a;

        tbl[0] = '{h: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, blk: '0, nblk: 0,
                   la: 64'd0, lc: 64'd0, exp: 128'd0};
        tbl[1] = '{h: {1'b1, 127'd0},
                   blk: {128'd0, {16{8'h22}}, {16{8'h11}}}, nblk: 2,
                   la: 64'd0, lc: 64'd256,
                   exp: 128'h3333_3333_3333_3333_3333_3333_3333_3233};
        tbl[2] = '{h: 128'd0,
                   blk: {128'hdeadbeef_01234567_89abcdef_00c0ffee,
                         128'h5555aaaa_0f0f0f0f_12345678_9abcdef0,
                         128'hffffffff_ffffffff_00000000_00000001}, nblk: 3,
                   la: 64'd128, lc: 64'd256, exp: 128'd0};
        tbl[3] = '{h: {2'b01, 126'd0}, blk: {128'd0, 128'd0, {1'b1, 127'd0}}, nblk: 1,
                   la: 64'd0, lc: 64'd0, exp: {3'b001, 125'd0}};
        tbl[4] = '{h: 128'd1, blk: {128'd0, 128'd0, {2'b01, 126'd0}}, nblk: 1,
                   la: 64'd0, lc: 64'd0, exp: 128'h92040000_00000000_00000000_00000001};
        tbl[5] = '{h: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                   blk: {128'd0, 128'd0, 128'h0388dace60b6a392f328c2b971b2fe78}, nblk: 1,
                   la: 64'd0, lc: 64'd128, exp: 128'd0};
        tbl[5].exp = ghash_ref(tbl[5]);

        repeat (3) tick();
        check("reset_outputs", {oGhash, oGhash_valid, oBlock_ready, oBusy}, 131'd0);
        iRst = 1'b0;
        tick();
        iBlock_valid = 1'b1;
        repeat (3) tick();
        iBlock_valid = 1'b0;
        check("idle_ignores_block", {125'd0, oBlock_ready, oBusy, oGhash_valid}, 128'd0);

        for (int i = 0; i < 6; i++) run_msg(tbl[i], $sformatf("vec%0d", i));

        // Block and iFinal together: block wins, the length block is not processed.
        iHashkey = {1'b1, 127'd0};
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        a = 128'h0123456789abcdef_fedcba9876543210;
        iBlock = a;
        iLen_aad = 64'd8;
        iLen_ct = 64'd16;
        iBlock_valid = 1'b1;
        iFinal = 1'b1;
        tick();
        iBlock_valid = 1'b0;
        iFinal = 1'b0;
        check("coll_busy", 128'(oBusy), 128'd1);
        wait_ready(n);
        check("coll_rdy_low", 128'(n), 128'd128);
        check("coll_no_len", 128'(oGhash_valid), 128'd0);
        iLen_aad = 64'h40;
        iLen_ct = 64'h80;
        iFinal = 1'b1;
        tick();
        iFinal = 1'b0;
        wait_ghash(n);
        check("coll_ghash", oGhash, 128'h0123456789abcdaf_fedcba9876543290);

        // Abort 60 cycles into a multiplication, then a fresh message under a new key.
        iHashkey = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        iBlock = 128'hcafebabe_cafebabe_cafebabe_cafebabe;
        iBlock_valid = 1'b1;
        tick();
        iBlock_valid = 1'b0;
        repeat (60) tick();
        check("abort_pre_busy", 128'(oBusy), 128'd1);
        va = '{h: 128'hb83b533708bf535d0aa6e52980d53b78,
               blk: {128'd0, 128'h42831ec2217774244b7221b784d0d49c,
                     128'hd9313225f88406e5a55909c5aff5269a}, nblk: 2,
               la: 64'd0, lc: 64'd256, exp: 128'd0};
        va.exp = ghash_ref(va);
        iHashkey = va.h;
        iStart = 1'b1;
        iBlock_valid = 1'b1;
        tick();
        iStart = 1'b0;
        iBlock_valid = 1'b0;
        check("abort_flags", {125'd0, oBlock_ready, oBusy, oGhash_valid}, 128'b100);
        send_body(va, "abort_msg");

        // Asynchronous reset in LMUL.
        iHashkey = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        iLen_aad = 64'd5;
        iLen_ct = 64'd7;
        iFinal = 1'b1;
        tick();
        iFinal = 1'b0;
        repeat (20) tick();
        check("rst_pre_busy", 128'(oBusy), 128'd1);
        #2 iRst = 1'b1;
        #1;
        check("rst_async", {oGhash, oGhash_valid, oBlock_ready, oBusy}, 131'd0);
        tick();
        iRst = 1'b0;
        iBlock_valid = 1'b1;
        iFinal = 1'b1;
        repeat (140) tick();
        iBlock_valid = 1'b0;
        iFinal = 1'b0;
        check("rst_stays_idle", {oGhash, oGhash_valid, oBlock_ready, oBusy}, 131'd0);
        run_msg(tbl[5], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
